// File: rtl/joy_db15_pkg.sv
// Shared constants for the DB15 joystick link: frame geometry, button bit
// positions and the helper that assembles the two-player load word.
package joy_db15_pkg;

  localparam int unsigned JOY_DB15_NBITS = 24;
  localparam int unsigned JOY_DB15_PBITS = 12;

  // Bit positions inside one player's 12-bit state word
  localparam int unsigned JOY_R = 0;
  localparam int unsigned JOY_L = 1;
  localparam int unsigned JOY_D = 2;
  localparam int unsigned JOY_U = 3;
  localparam int unsigned JOY_A = 4;
  localparam int unsigned JOY_B = 5;
  localparam int unsigned JOY_C = 6;
  localparam int unsigned JOY_E = 7;
  localparam int unsigned JOY_F = 8;
  localparam int unsigned JOY_G = 9;
  localparam int unsigned JOY_X = 10;
  localparam int unsigned JOY_H = 11;

  // Player 1 occupies the low half so its R button is shifted out first
  function automatic logic [2*JOY_DB15_PBITS-1:0] joy_word(
    input logic [JOY_DB15_PBITS-1:0] p1,
    input logic [JOY_DB15_PBITS-1:0] p2
  );
    return {p2, p1};
  endfunction

endpackage

// File: rtl/joy_db15_tx_if.sv
// DB15 serial link as seen on the connector: host drives clock and load,
// target returns active-low serial data.
interface joy_db15_tx_if;
  logic joy_clk;
  logic joy_load;
  logic joy_data;

  modport master (
    output joy_clk,
    output joy_load,
    input  joy_data
  );

  modport slave (
    input  joy_clk,
    input  joy_load,
    output joy_data
  );
endinterface

// File: rtl/joy_sync_edge.sv
// Synchronizer plus edge detector for one asynchronous link input.
// With JOY_DB15_TX_DEGLITCH_EN defined, a stability filter of DEGLITCH_CYCLES
// sits between the synchronizer and the edge detector.
module joy_sync_edge #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEGLITCH_CYCLES = 3,
  parameter logic        RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

`ifdef JOY_DB15_TX_DEGLITCH_EN
  localparam int unsigned FiltLen = DEGLITCH_CYCLES;
`else
  // Filter absent in this build; the length parameter has no effect
  localparam int unsigned FiltLen = 0 * DEGLITCH_CYCLES;
`endif

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   synced;
  logic                   prev_q, prev_d;

  // Shift the raw pin level through the synchronizer chain
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  // Synchronizer flops
  always_ff @(posedge clk) begin
    if (reset) sync_q <= {SYNC_STAGES{RESET_VAL}};
    else       sync_q <= sync_d;
  end

  assign synced = sync_q[SYNC_STAGES-1];

  if (FiltLen > 0) begin : g_filt
    localparam int unsigned CW = $clog2(FiltLen + 1);
    localparam logic [CW-1:0] CntLast = CW'(FiltLen - 1);

    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Accept a new level only after it has held for FiltLen cycles
    always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (synced != filt_q) begin
        if (cnt_q == CntLast) filt_d = synced;
        else                  cnt_d  = cnt_q + CW'(1);
      end
    end

    // Filter state
    always_ff @(posedge clk) begin
      if (reset) begin
        filt_q <= RESET_VAL;
        cnt_q  <= '0;
      end else begin
        filt_q <= filt_d;
        cnt_q  <= cnt_d;
      end
    end

    assign level = filt_q;
  end else begin : g_nofilt
    assign level = synced;
  end

  // Previous level for edge detection
  always_comb begin
    prev_d = level;
  end

  // Edge-detect flop
  always_ff @(posedge clk) begin
    if (reset) prev_q <= RESET_VAL;
    else       prev_q <= prev_d;
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

endmodule

// File: rtl/joy_db15_tx.sv
// Target-side DB15 joystick responder: emulates the adapter's parallel-in /
// serial-out chain, returning both players' buttons active-low on joy_data.
// Optional input deglitch filter: define JOY_DB15_TX_DEGLITCH_EN.
module joy_db15_tx
  import joy_db15_pkg::*;
#(
  parameter int unsigned NBITS           = JOY_DB15_NBITS,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000,
  parameter int unsigned DEGLITCH_CYCLES = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [JOY_DB15_PBITS-1:0] joystick1,
  input  logic [JOY_DB15_PBITS-1:0] joystick2,
  joy_db15_tx_if.slave              link,
  output logic                      frame_done,
  output logic                      overrun,
  output logic                      link_active
);

  localparam int unsigned WordBits = 2 * JOY_DB15_PBITS;
  localparam int unsigned CntW     = $clog2(NBITS + 1);
  localparam int unsigned TmoW     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CntW-1:0] CntMax    = CntW'(NBITS);
  localparam logic [CntW-1:0] CntLast   = CntW'(NBITS - 1);
  localparam logic [CntW-1:0] CntPenult = CntW'(NBITS - 2);
  localparam logic [TmoW-1:0] TmoMax    = TmoW'(TIMEOUT_CYCLES);

  logic clk_level, clk_rise, unused_clk_fall;
  logic load_level, load_fall, unused_load_rise;

  logic [NBITS-1:0]          shreg_q, shreg_d;
  logic [CntW-1:0]           bit_cnt_q, bit_cnt_d;
  logic                      overrun_q, overrun_d;
  logic                      frame_done_q, frame_done_d;
  logic [TmoW-1:0]           tmo_q, tmo_d;
  logic                      active_q, active_d;
  logic [NBITS+WordBits-1:0] load_word;

  joy_sync_edge #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEGLITCH_CYCLES (DEGLITCH_CYCLES),
    .RESET_VAL       (1'b0)
  ) u_clk_sync (
    .clk   (clk),
    .reset (reset),
    .din   (link.joy_clk),
    .level (clk_level),
    .rise  (clk_rise),
    .fall  (unused_clk_fall)
  );

  // Load idles high, so reset it high to avoid a spurious load after reset
  joy_sync_edge #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEGLITCH_CYCLES (DEGLITCH_CYCLES),
    .RESET_VAL       (1'b1)
  ) u_load_sync (
    .clk   (clk),
    .reset (reset),
    .din   (link.joy_load),
    .level (load_level),
    .rise  (unused_load_rise),
    .fall  (load_fall)
  );

  // Pad above the player word with ones so a longer chain reads "not pressed"
  assign load_word = {{NBITS{1'b1}}, ~joy_word(joystick1, joystick2)};

  // Shift chain: load has priority over a coincident clock rise
  always_comb begin
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    overrun_d    = overrun_q;
    frame_done_d = 1'b0;
    if (!load_level) begin
      shreg_d   = load_word[NBITS-1:0];
      bit_cnt_d = '0;
      overrun_d = 1'b0;
    end else if (clk_rise) begin
      shreg_d = {1'b1, shreg_q[NBITS-1:1]};
      if (bit_cnt_q >= CntLast)   overrun_d    = 1'b1;
      if (bit_cnt_q == CntPenult) frame_done_d = 1'b1;
      if (bit_cnt_q != CntMax)    bit_cnt_d    = bit_cnt_q + CntW'(1);
    end
  end

  // Link watchdog: any load fall re-arms it
  always_comb begin
    tmo_d    = tmo_q;
    active_d = active_q;
    if (load_fall) begin
      tmo_d    = '0;
      active_d = 1'b1;
    end else if (tmo_q != TmoMax) begin
      tmo_d = tmo_q + TmoW'(1);
      if (tmo_d == TmoMax) active_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q      <= '1;
      bit_cnt_q    <= '0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
      tmo_q        <= '0;
      active_q     <= 1'b0;
    end else begin
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
      tmo_q        <= tmo_d;
      active_q     <= active_d;
    end
  end

  assign link.joy_data = shreg_q[0];
  assign frame_done    = frame_done_q;
  assign overrun       = overrun_q;
  assign link_active   = active_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed bench for joy_db15_tx: frame contents, frame_done, overrun, load
// priority, pin-to-data latency, link timeout and mid-frame reset.
module tb_joy_db15_tx;

`ifdef JOY_DB15_TX_DEGLITCH_EN
  localparam int Lat = 6;
`else
  localparam int Lat = 3;
`endif

  logic        clk;
  logic        reset;
  logic [11:0] joystick1;
  logic [11:0] joystick2;
  logic        frame_done;
  logic        overrun;
  logic        link_active;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fd_count  = 0;

  joy_db15_tx_if link_if ();

  joy_db15_tx #(
    .NBITS           (24),
    .SYNC_STAGES     (2),
    .TIMEOUT_CYCLES  (100),
    .DEGLITCH_CYCLES (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .joystick1   (joystick1),
    .joystick2   (joystick2),
    .link        (link_if),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .link_active (link_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_done pulses away from the active edge
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_count = fd_count + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_load();
    link_if.joy_load = 1'b0;
    tick(Lat + 3);
    link_if.joy_load = 1'b1;
    tick(Lat + 5);
  endtask

  task automatic do_shift();
    link_if.joy_clk = 1'b1;
    tick(Lat + 2);
    link_if.joy_clk = 1'b0;
    tick(Lat + 2);
  endtask

  // Hand-computed streams: ~{12'h008,12'h011} and ~{12'h3F1,12'hA5C}
  logic [23:0] exp_a = 24'hFF7FEE;
  logic [23:0] exp_b = 24'hC0E5A3;
  int          fd_base;

  initial begin
    reset            = 1'b1;
    joystick1        = 12'h011;
    joystick2        = 12'h008;
    link_if.joy_clk  = 1'b0;
    link_if.joy_load = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state
    check("rst joy_data", 32'(link_if.joy_data), 32'd1);
    check("rst frame_done", 32'(frame_done), 32'd0);
    check("rst overrun", 32'(overrun), 32'd0);
    check("rst link_active", 32'(link_active), 32'd0);

    // Timeout: active one edge after the synced fall, gone 100 edges later
    link_if.joy_load = 1'b0;
    tick(Lat - 1);
    check("tmo before fall", 32'(link_active), 32'd0);
    tick(1);
    check("tmo after fall", 32'(link_active), 32'd1);
    link_if.joy_load = 1'b1;
    tick(99);
    check("tmo at 99", 32'(link_active), 32'd1);
    tick(1);
    check("tmo at 100", 32'(link_active), 32'd0);

    // Basic frame plus two overrun shifts
    fd_base = fd_count;
    do_load();
    check("frame link_active", 32'(link_active), 32'd1);
    for (int i = 0; i < 26; i++) begin
      if (i < 24) check($sformatf("frame bit %0d", i), 32'(link_if.joy_data), 32'(exp_a[i]));
      else        check($sformatf("frame bit %0d", i), 32'(link_if.joy_data), 32'd1);
      if (i == 22) check("fd before last", 32'(fd_count - fd_base), 32'd0);
      if (i == 23) begin
        check("fd after last", 32'(fd_count - fd_base), 32'd1);
        check("no overrun at last", 32'(overrun), 32'd0);
      end
      if (i == 24) check("overrun set", 32'(overrun), 32'd1);
      do_shift();
    end
    check("overrun sticky", 32'(overrun), 32'd1);
    check("fd single pulse", 32'(fd_count - fd_base), 32'd1);

    // Next load clears overrun and re-presents bit 0
    do_load();
    check("reload overrun", 32'(overrun), 32'd0);
    check("reload bit 0", 32'(link_if.joy_data), 32'(exp_a[0]));

    // Load priority: synced clock rise lands in the last cycle of load low
    link_if.joy_load = 1'b0;
    tick(Lat + 3);
    link_if.joy_clk = 1'b1;
    tick(1);
    link_if.joy_load = 1'b1;
    tick(Lat + 5);
    check("prio no shift", 32'(link_if.joy_data), 32'(exp_a[0]));
    link_if.joy_clk = 1'b0;
    tick(Lat + 2);
    check("fall ignored", 32'(link_if.joy_data), 32'(exp_a[0]));

`ifdef JOY_DB15_TX_DEGLITCH_EN
    link_if.joy_clk = 1'b1;
    tick(2);
    link_if.joy_clk = 1'b0;
    tick(10);
    check("glitch no shift", 32'(link_if.joy_data), 32'(exp_a[0]));
`endif

    // Latency: pin rise to joy_data update in exactly Lat edges
    link_if.joy_clk = 1'b1;
    tick(Lat - 1);
    check("latency early", 32'(link_if.joy_data), 32'(exp_a[0]));
    tick(1);
    check("latency exact", 32'(link_if.joy_data), 32'(exp_a[1]));
    link_if.joy_clk = 1'b0;
    tick(Lat + 2);

    // Reset mid-frame after 10 shifts
    joystick1 = 12'hA5C;
    joystick2 = 12'h3F1;
    do_load();
    for (int i = 0; i < 10; i++) do_shift();
    check("mid bit 10", 32'(link_if.joy_data), 32'(exp_b[10]));
    reset = 1'b1;
    tick(1);
    check("mid rst joy_data", 32'(link_if.joy_data), 32'd1);
    check("mid rst bit_cnt", 32'(dut.bit_cnt_q), 32'd0);
    check("mid rst overrun", 32'(overrun), 32'd0);
    check("mid rst link_active", 32'(link_active), 32'd0);
    reset = 1'b0;
    tick(2);
    check("idle after rst", 32'(link_if.joy_data), 32'd1);

    // Full frame after reset
    fd_base = fd_count;
    do_load();
    for (int i = 0; i < 24; i++) begin
      check($sformatf("post bit %0d", i), 32'(link_if.joy_data), 32'(exp_b[i]));
      do_shift();
    end
    check("post fd", 32'(fd_count - fd_base), 32'd1);
    check("post overrun", 32'(overrun), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
